// File: rtl/clm_state_loader_pkg.sv
// Shared types for the masked-state loader: code matrix, encoded state and block buffer.
// Widths are fixed here so the loader, mod_p and the bench agree on bit ordering.
package clm_state_loader_pkg;

  localparam int D      = 8;
  localparam int NBYTES = 16;
  localparam int CNT_W  = $clog2(NBYTES);

  // Bits [0:7] carry the masked data byte, bits [8:7+D] carry the mask r.
  typedef logic [0:7+D]      state_t;
  typedef logic [0:D-1][0:7] dm_matrix_t;
  typedef state_t            state_array_t [0:NBYTES-1];

  typedef enum logic {COLLECT, EMIT} fsm_e;

endpackage

// File: rtl/clm_state_loader_if.sv
// Plaintext, random-word and encoded-block handshakes of the state loader.
// The loader takes the slave modport, the traffic source/sink the master modport.
interface clm_state_loader_if;
  import clm_state_loader_pkg::*;

  logic           pt_valid;
  logic           pt_ready;
  logic [0:7]     pt_byte;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [0:D-1]   rnd;
  logic           st_valid;
  logic           st_ready;
  state_array_t   st_out;

  modport master (
    output pt_valid, pt_byte, rnd_valid, rnd, st_ready,
    input  pt_ready, rnd_ready, st_valid, st_out
  );

  modport slave (
    input  pt_valid, pt_byte, rnd_valid, rnd, st_ready,
    output pt_ready, rnd_ready, st_valid, st_out
  );

endinterface

// File: rtl/clm_state_loader_mod_p.sv
// Systematic-syndrome reduction: x_o[i] = s[i] ^ parity(B[*][i] & s[8:7+D]).
// Purely combinational; applied to {x, r} it produces the masked byte x ^ B^T*r.
module clm_state_loader_mod_p
  import clm_state_loader_pkg::*;
(
  input  state_t     state_i,
  input  dm_matrix_t b_i,
  output logic [0:7] x_o
);

  always_comb begin
    x_o = '0;
    for (int i = 0; i < 8; i++) begin
      x_o[i] = state_i[i];
      for (int j = 0; j < D; j++) begin
        x_o[i] = x_o[i] ^ (b_i[j][i] & state_i[8+j]);
      end
    end
  end

endmodule

// File: rtl/clm_state_loader.sv
// Collects NBYTES masked states (one per joint pt/rnd accept) and offers the block downstream.
// st_valid rises the cycle after the last accept; block is held, inputs stalled, until st_ready.
module clm_state_loader
  import clm_state_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  dm_matrix_t            b_i,
  clm_state_loader_if.slave     st_if,
  output logic                  busy_o
);

  fsm_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_array_t     buf_q, buf_d;
  logic [0:7]       enc_dat;
  logic             acc;
  logic             st_vld;

  // Reduction of the raw {x, r} pair is exactly the masked data half.
  clm_state_loader_mod_p u_enc (
    .state_i ({st_if.pt_byte, st_if.rnd}),
    .b_i     (b_i),
    .x_o     (enc_dat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    acc     = 1'b0;
    st_vld  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        // Both channels move together; reset wins over a same-cycle accept.
        acc = st_if.pt_valid & st_if.rnd_valid & ~rst;
        if (acc) begin
          buf_d[cnt_q] = {enc_dat, st_if.rnd};
          if (cnt_q == CNT_W'(NBYTES-1)) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        st_vld = 1'b1;
        if (st_if.st_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign st_if.pt_ready  = acc;
  assign st_if.rnd_ready = acc;
  assign st_if.st_valid  = st_vld;
  assign st_if.st_out    = buf_q;
  assign busy_o          = (state_q != COLLECT) || (cnt_q != '0);

endmodule

// File: doc/clm_state_loader.md
Name: clm_state_loader

Overview:
- Byte-serial input stage that feeds the masked datapath.
- Each accepted plaintext byte x is paired with d fresh random bits r and encoded as state_t = {x ^ B^T·r, r}, using the same B matrix the downstream systematic-syndrome reduction (mod_P) uses. mod_P applied to the stored state therefore returns x.
- Buffers NBYTES encoded states and hands the full block downstream with a valid/ready handshake.

Parameters:
d, 8, number of redundancy (mask) bits per state; state_t width is 8+d.
NBYTES, 16, states per block (AES state size).

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
B  in  dm_matrix_t (d x 8)  code matrix; must be stable for the whole block.
pt_valid  in  1  plaintext byte available.
pt_ready  out  1  plaintext byte consumed this cycle.
pt_byte  in  [0:7]  plaintext byte.
rnd_valid  in  1  fresh random word available.
rnd_ready  out  1  random word consumed this cycle.
rnd  in  [0:d-1]  fresh random bits.
st_valid  out  1  full encoded block available.
st_ready  in  1  downstream accepts block.
st_out  out  state_array_t (NBYTES x state_t)  encoded block; element k holds plaintext byte k.
busy  out  1  high when state != COLLECT or cnt != 0.

Behaviour:
- FSM states:
  - COLLECT (reset state): gathering bytes.
  - EMIT: block held for downstream.
- Counter cnt is ceil(log2 NBYTES) bits, reset 0.
- Joint accept in COLLECT:
  - acc = pt_valid & rnd_valid.
  - pt_ready = rnd_ready = acc. Both channels are consumed together or not at all.
  - Sources must not make valid depend on ready.
- On acc:
  - buf[cnt][0:7] <= pt_byte ^ (B^T·rnd): bit i = pt_byte[i] ^ parity(B[*][i] & rnd).
  - buf[cnt][8:7+d] <= rnd.
  - cnt increments.
- Last byte: acc with cnt == NBYTES-1 sets cnt <= 0 and goes to EMIT next cycle. st_valid rises the cycle after the last accept.
- EMIT:
  - st_valid = 1; pt_ready = rnd_ready = 0.
  - st_out is stable until the handshake completes.
  - On st_ready: return to COLLECT next cycle. A new byte can be accepted in that next cycle, not in the handshake cycle.
- st_out is continuously driven from buf in all states. Its value is only meaningful while st_valid is high.
- Buffer contents are retained after the handshake and overwritten byte by byte by the next block.
- Throughput: at most one byte per cycle. Minimum block period is NBYTES+1 cycles with no stalls and st_ready held high.
- Stalls:
  - If only one of pt_valid/rnd_valid is high, nothing is accepted and cnt holds.
  - st_ready while in COLLECT is ignored.
- Reset values (rst in any state, including mid-block or mid-EMIT):
  - state=COLLECT, cnt=0, all buf bits 0.
  - st_valid=0, pt_ready=0, rnd_ready=0, busy=0.
  - The partial block is discarded.
- rst has priority over any simultaneous handshake.
- No arithmetic beyond GF(2): XOR/AND only, no carries.
- cnt wraps only via the explicit last-byte rule; it never exceeds NBYTES-1.

Decomposition:
- Package types gains:
  - NBYTES (localparam 16).
  - state_array_t, an unpacked array [0:NBYTES-1] of state_t.
- state_t and dm_matrix_t are reused unchanged.
- Encoding instantiates one existing mod_P on {pt_byte, rnd}. Its output is x ^ B^T·r, which is the encoded data half, so no new sub-module is needed.
- FSM, counter and buffer stay in this module.

Test Plan:
- Identity: d=8, B = identity (B[j][i]=1 iff i==j), all 16 bytes pt=0x3A, rnd=0xFF.
  -> st_valid on cycle 17 after the first accept; every st_out[k] = {0xC5, 0xFF}; pt_ready high for exactly 16 cycles.
- Zero matrix: B = all-zero, pt = 0x00..0x0F, rnd = 0xA5.
  -> st_out[k] = {k, 0xA5}; mod_P on each element returns k.
- Independent stalls: random pt_valid/rnd_valid toggling, with rnd high only every other cycle.
  -> bytes accepted only when both valid; order preserved; cnt never skips.
- Backpressure: in EMIT, hold st_ready=0 for 10 cycles with pt_valid=rnd_valid=1.
  -> st_out stable, pt_ready=rnd_ready=0 throughout; after st_ready, COLLECT resumes next cycle.
- Reset mid-block: assert rst after 5 accepts, then send a fresh 16-byte block.
  -> outputs zero the cycle after rst; the new block appears at indices 0..15 with no stale bytes.
- Random round-trip: random B, pt, rnd over 1000 blocks.
  -> mod_P(st_out[k], B) equals pt byte k for all k.
